// File: rtl/mul_err_sweep.sv
// Exhaustive error-characterisation sweep for an external approximate WIDTHxWIDTH multiplier.
// Drives every operand pair and accumulates error count, error sum and first worst-case error.
module mul_err_sweep #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 result_valid,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_c,
    output logic [2*WIDTH:0]     err_count,
    output logic [4*WIDTH-1:0]   err_sum,
    output logic [2*WIDTH-1:0]   err_max,
    output logic [WIDTH-1:0]     max_a,
    output logic [WIDTH-1:0]     max_b,
    output logic [1:0]           dbg_state
);

    // Handshake: start is a level sampled on a rising edge only while IDLE or DONE;
    // abort is sampled on every edge and wins over start; done is a one-cycle pulse.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]   ONE_W = 1;
    localparam logic [2*WIDTH:0]   ONE_C = 1;

    state_t                r_state;
    state_t                w_next;
    logic                  w_launch;
    logic                  w_last_pair;

    logic [WIDTH-1:0]      r_mul_a;
    logic [WIDTH-1:0]      r_mul_b;
    logic                  r_result_valid;

    logic                  r_s1_v;
    logic [2*WIDTH-1:0]    r_s1_c;
    logic [2*WIDTH-1:0]    r_s1_p;
    logic [WIDTH-1:0]      r_s1_a;
    logic [WIDTH-1:0]      r_s1_b;
    logic [2*WIDTH-1:0]    w_prod;
    logic [2*WIDTH-1:0]    w_diff;

    logic [2*WIDTH:0]      r_err_count;
    logic [4*WIDTH-1:0]    r_err_sum;
    logic [2*WIDTH-1:0]    r_err_max;
    logic [WIDTH-1:0]      r_max_a;
    logic [WIDTH-1:0]      r_max_b;

    assign w_last_pair = (r_mul_a == {WIDTH{1'b1}}) && (r_mul_b == {WIDTH{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // DONE behaves like IDLE for start/abort so a new sweep can launch during the done pulse.
    always_comb begin
        w_next   = r_state;
        w_launch = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_next = ST_IDLE;
                if (!abort && start) begin
                    w_next   = ST_RUN;
                    w_launch = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (w_last_pair) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_next = abort ? ST_IDLE : ST_DONE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Operand counter: b is the inner index, a the outer; holds on the final pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else if (w_launch) begin
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else if (r_state == ST_RUN && !abort && !w_last_pair) begin
            if (r_mul_b == {WIDTH{1'b1}}) begin
                r_mul_b <= '0;
                r_mul_a <= r_mul_a + ONE_W;
            end else begin
                r_mul_b <= r_mul_b + ONE_W;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result_valid <= 1'b0;
        end else if (abort || w_launch) begin
            r_result_valid <= 1'b0;
        end else if (r_state == ST_DRAIN) begin
            r_result_valid <= 1'b1;
        end
    end

    assign w_prod = {{WIDTH{1'b0}}, r_mul_a} * {{WIDTH{1'b0}}, r_mul_b};

    // Stage 1: capture the multiplier output alongside the exact reference product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v <= 1'b0;
            r_s1_c <= '0;
            r_s1_p <= '0;
            r_s1_a <= '0;
            r_s1_b <= '0;
        end else begin
            r_s1_v <= (r_state == ST_RUN) && !abort;
            r_s1_c <= mul_c;
            r_s1_p <= w_prod;
            r_s1_a <= r_mul_a;
            r_s1_b <= r_mul_b;
        end
    end

    assign w_diff = (r_s1_c >= r_s1_p) ? (r_s1_c - r_s1_p) : (r_s1_p - r_s1_c);

    // Stage 2: accumulate; strict compare keeps the earliest pair on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
            r_err_sum   <= '0;
            r_err_max   <= '0;
            r_max_a     <= '0;
            r_max_b     <= '0;
        end else if (w_launch) begin
            r_err_count <= '0;
            r_err_sum   <= '0;
            r_err_max   <= '0;
            r_max_a     <= '0;
            r_max_b     <= '0;
        end else if (r_s1_v && !abort) begin
            if (w_diff != '0) begin
                r_err_count <= r_err_count + ONE_C;
                r_err_sum   <= r_err_sum + {{(2*WIDTH){1'b0}}, w_diff};
            end
            if (w_diff > r_err_max) begin
                r_err_max <= w_diff;
                r_max_a   <= r_s1_a;
                r_max_b   <= r_s1_b;
            end
        end
    end

    assign busy         = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done         = (r_state == ST_DONE);
    assign result_valid = r_result_valid;
    assign mul_a        = r_mul_a;
    assign mul_b        = r_mul_b;
    assign err_count    = r_err_count;
    assign err_sum      = r_err_sum;
    assign err_max      = r_err_max;
    assign max_a        = r_max_a;
    assign max_b        = r_max_b;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_mul_err_sweep.sv
// Bench for mul_err_sweep at WIDTH=4: a behavioural sweep model checks outputs every cycle
// against several multiplier fault models, including randomized error tables.
module tb_mul_err_sweep;

    localparam int W  = 4;
    localparam int NS = 1 << W;
    localparam int N  = NS * NS;

    typedef struct {
        longint cnt;
        longint sum;
        longint mx;
        longint a;
        longint b;
    } stats_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              result_valid;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [2*W-1:0]    mul_c;
    logic [2*W:0]      err_count;
    logic [4*W-1:0]    err_sum;
    logic [2*W-1:0]    err_max;
    logic [W-1:0]      max_a;
    logic [W-1:0]      max_b;
    logic [1:0]        dbg_state;

    logic [1:0]        mode;
    logic [2*W-1:0]    err_tab [0:N-1];
    logic [2*W-1:0]    w_exact;

    int                n_chk = 0;
    int                n_err = 0;

    always #5 clk = ~clk;

    mul_err_sweep #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .result_valid(result_valid),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .err_count(err_count), .err_sum(err_sum), .err_max(err_max),
        .max_a(max_a), .max_b(max_b), .dbg_state(dbg_state)
    );

    // Multiplier under test: 0 exact, 1 LSB cleared, 2 constant zero, 3 random error table.
    assign w_exact = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    assign mul_c = (mode == 2'd0) ? w_exact :
                   (mode == 2'd1) ? (w_exact & ~{{(2*W-1){1'b0}}, 1'b1}) :
                   (mode == 2'd2) ? '0 : (w_exact ^ err_tab[{mul_a, mul_b}]);

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic stats_t ref_stats(input logic [1:0] md);
        stats_t s;
        longint p, c, d;
        s = '{default: 0};
        for (int a = 0; a < NS; a++) begin
            for (int b = 0; b < NS; b++) begin
                p = a * b;
                case (md)
                    2'd0:    c = p;
                    2'd1:    c = p - (p % 2);
                    2'd2:    c = 0;
                    default: c = p ^ longint'(err_tab[a * NS + b]);
                endcase
                d = (c > p) ? c - p : p - c;
                if (d != 0) begin
                    s.cnt++;
                    s.sum += d;
                end
                if (d > s.mx) begin
                    s.mx = d;
                    s.a  = a;
                    s.b  = b;
                end
            end
        end
        return s;
    endfunction

    // Sweep model: m_k is the cycle index since the start edge, -1 when not sweeping.
    int     m_k;
    logic   m_done;
    logic   m_rv;
    stats_t e_st;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k    <= -1;
            m_done <= 1'b0;
            m_rv   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_k >= 0) begin
                if (abort) begin
                    m_k <= -1;
                end else if (m_k == N) begin
                    m_k    <= -1;
                    m_done <= 1'b1;
                    m_rv   <= 1'b1;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (abort) begin
                m_rv <= 1'b0;
            end else if (start) begin
                m_k  <= 0;
                m_rv <= 1'b0;
                e_st <= ref_stats(mode);
            end
        end
    end

    always @(negedge clk) begin
        int p;
        chk("busy", longint'(busy), longint'(m_k >= 0));
        chk("done", longint'(done), longint'(m_done));
        chk("result_valid", longint'(result_valid), longint'(m_rv));
        if (m_k >= 0) begin
            p = (m_k < N) ? m_k : N - 1;
            chk("mul_a", longint'(mul_a), longint'(p / NS));
            chk("mul_b", longint'(mul_b), longint'(p % NS));
        end
        if (m_k == 0 || m_k == 1) begin
            chk("cleared_count", longint'(err_count), 0);
            chk("cleared_max", longint'(err_max), 0);
            chk("cleared_max_a", longint'(max_a), 0);
        end
        if (m_rv) begin
            chk("err_count", longint'(err_count), e_st.cnt);
            chk("err_sum", longint'(err_sum), e_st.sum);
            chk("err_max", longint'(err_max), e_st.mx);
            chk("max_a", longint'(max_a), e_st.a);
            chk("max_b", longint'(max_b), e_st.b);
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_rv"}, longint'(result_valid), 0);
        chk({tag, "_mul_a"}, longint'(mul_a), 0);
        chk({tag, "_mul_b"}, longint'(mul_b), 0);
        chk({tag, "_err_count"}, longint'(err_count), 0);
        chk({tag, "_err_sum"}, longint'(err_sum), 0);
        chk({tag, "_err_max"}, longint'(err_max), 0);
        chk({tag, "_max_a"}, longint'(max_a), 0);
        chk({tag, "_max_b"}, longint'(max_b), 0);
    endtask

    // Launch a sweep and wait for done; ign_at pulses start mid-sweep (must be ignored).
    task automatic do_sweep(input logic [1:0] md, input int ign_at, input bit b2b);
        bit got;
        got = 1'b0;
        if (!b2b) @(negedge clk);
        mode  = md;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= N + 20; i++) begin
            @(negedge clk);
            start = (i == ign_at);
            if (done) begin
                chk("done_latency", i, N + 1);
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!got) chk("done_timeout", 0, 1);
    endtask

    task automatic start_then_abort(input int at_k);
        @(negedge clk);
        mode  = 2'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (at_k) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("busy_after_abort", longint'(busy), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic randomize_table();
        for (int i = 0; i < N; i++)
            err_tab[i] = ($urandom_range(0, 3) == 0) ? (2*W)'($urandom) : '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stats_t s;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode  = 2'd0;
        for (int i = 0; i < N; i++) err_tab[i] = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Hand-computed values pinning the reference model at WIDTH=4.
        s = ref_stats(2'd1);
        chk("model_lsb_cnt", s.cnt, 64);
        chk("model_lsb_max_a", s.a, 1);
        s = ref_stats(2'd2);
        chk("model_zero_sum", s.sum, 14400);
        chk("model_zero_max", s.mx, 225);

        do_sweep(2'd0, 0, 1'b0);
        chk("exact_count", longint'(err_count), 0);
        chk("exact_sum", longint'(err_sum), 0);
        chk("exact_max", longint'(err_max), 0);

        do_sweep(2'd1, 50, 1'b0);
        chk("lsb_count", longint'(err_count), 64);
        chk("lsb_sum", longint'(err_sum), 64);
        chk("lsb_max", longint'(err_max), 1);
        chk("lsb_max_a", longint'(max_a), 1);
        chk("lsb_max_b", longint'(max_b), 1);

        do_sweep(2'd2, 0, 1'b1);
        chk("zero_count", longint'(err_count), 225);
        chk("zero_sum", longint'(err_sum), 14400);
        chk("zero_max", longint'(err_max), 225);
        chk("zero_max_a", longint'(max_a), 15);
        chk("zero_max_b", longint'(max_b), 15);

        for (int r = 0; r < 3; r++) begin
            randomize_table();
            repeat ($urandom_range(0, 4)) @(negedge clk);
            do_sweep(2'd3, $urandom_range(1, N), r[0]);
        end

        start_then_abort(5);
        start_then_abort(N);
        start_then_abort($urandom_range(0, N));
        randomize_table();
        do_sweep(2'd3, 0, 1'b0);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat ($urandom_range(3, N - 3)) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("start_abort_idle", longint'(busy), 0);
        do_sweep(2'd1, 0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
